tx_ordered_set_framer: RTL and testbench
========================================

// Module: tx_ordered_set_framer
// PURPOSE
// - TX symbol source feeding multi_lane_controller (drives data_frame_i/_valid_i, is_ordered_set_i, bypass_scrambler_i).
// - Muxes DLLP/TLP bytes with generated Gen1 ordered sets: periodic SKP OS and requested TS1/TS2 OS; idle (0x00) otherwise.
// - Inserts OS only at packet boundaries; back-pressures the packet source while an OS is sent.
// PARAMETERS
// - SKP_INTERVAL  default 1180  symbol cycles between SKP OS insertions (legal 16..4095)
// - N_FTS         default 8'd16 N_FTS byte placed in TS symbol 3
// PORTS
// - clk_i              in   1   clock
// - rst_i              in   1   synchronous active-high reset
// - tx_enable_i        in   1   framer active; low = abort to IDLE
// - pkt_byte_i         in   8   DLLP/TLP byte
// - pkt_valid_i        in   1   pkt_byte_i valid
// - pkt_sop_i          in   1   first byte of packet (qualified by valid)
// - pkt_eop_i          in   1   last byte of packet (qualified by valid)
// - pkt_ready_o        out  1   byte accepted when valid&ready (combinational)
// - ts_req_i           in   1   level: send TS OS back-to-back while high
// - ts_type_i          in   1   0=TS1 (ID 0x4A), 1=TS2 (ID 0x45); sampled at COM
// - link_num_i         in   8   TS symbol 1 (0xF7 = PAD)
// - lane_num_i         in   8   TS symbol 2 (0xF7 = PAD)
// - ts_done_o          out  1   1-cycle pulse with last TS symbol
// - data_frame_o       out  8   symbol to controller
// - data_frame_valid_o out  1   data_frame_o valid
// - is_k_o             out  1   data_frame_o is K symbol
// - is_ordered_set_o   out  1   symbol belongs to an OS
// - bypass_scrambler_o out  1   symbol must not be scrambled
// BEHAVIOUR
// - Reset: FSM=IDLE, SKP counter=0, skp_pending=0, all outputs 0.
// - Outputs registered; 1 cycle from accept/generate to output. pkt_ready_o = tx_enable_i & (state==PKT | (state==IDLE & !skp_pending & !ts_req_i)).
// - SKP counter increments every tx_enable_i cycle; at SKP_INTERVAL-1 sets skp_pending, wraps to 0. Pending stays set until SKP COM emitted.
// - FSM IDLE: priority skp_pending > ts_req_i > pkt_valid&pkt_sop > idle symbol (0x00, valid=1, K=0, OS=0, bypass=0).
//   IDLE->SKP / IDLE->TS; IDLE->PKT on accepted SOP byte without EOP (SOP&EOP = 1-byte packet, stay IDLE).
// - PKT: forward bytes, valid=1 only when accepted; a valid-low gap emits valid=0 (no idle filler); SKP/TS deferred; ->IDLE on accepted EOP.
//   SOP seen in PKT: treated as data (no realignment). Non-SOP byte in IDLE: not accepted (ready high, byte dropped), idle emitted.
// - SKP: 4 symbols: 0xBC K, 0x1C K x3; OS=1, bypass=1. Clears skp_pending at COM. ->IDLE after symbol 3.
// - TS: 16 symbols: 0xBC K, link, lane, N_FTS, 0x02 (2.5GT/s), 0x00 (training ctrl), 10x ID; symbols 1..2 K=1 iff value 0xF7.
//   OS=1, bypass=1. ts_done_o with symbol 15. ->TS again if ts_req_i high and !skp_pending, else IDLE.
// - skp_pending rising during SKP/TS: served at next IDLE decision; counter never stalls (late SKP is accepted).
// - tx_enable_i low: next cycle FSM=IDLE, symbol index cleared, counter=0, pending cleared, outputs valid=0; in-flight packet/OS truncated.
// - rst_i mid-OS or mid-packet: identical to reset values next cycle; no ts_done_o.
// CONFIGURATION
// - TX_OS_STATS_EN defined: outputs skp_count_o[15:0], ts_count_o[15:0]; increment on each COM emitted; saturate at 0xFFFF; cleared by rst_i.
// - TX_OS_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset, tx_enable_i=1, no traffic, SKP_INTERVAL=16 -> 0x00 idles; SKP OS BC,1C,1C,1C (K=1,OS=1,bypass=1) starts every 16 cycles.
// - 8-byte packet (SOP..EOP, 0x10..0x17) with SKP due at byte 3 -> bytes contiguous, SKP immediately after EOP, pkt_ready_o low during SKP.
// - ts_req_i=1, ts_type_i=0, link=0xF7, lane=0xF7 -> BC,F7K,F7K,10,02,00,4Ax10; ts_done_o on 16th; repeats while held.
// - ts_req_i and skp_pending both set in IDLE -> SKP first, then TS; ts_type_i=1 -> ID 0x45.
// - tx_enable_i dropped at TS symbol 7 -> valid=0 next cycle, no ts_done_o; re-enable restarts TS at COM.
// - TX_OS_STATS_EN: 3 SKP + 2 TS sent -> skp_count_o=3, ts_count_o=2; force 0xFFFF -> stays 0xFFFF.

Source files
------------

// File: rtl/tx_ordered_set_framer.sv
// tx_ordered_set_framer: TX symbol source that interleaves DLLP/TLP bytes with
// Gen1 ordered sets (periodic SKP, requested TS1/TS2) and 0x00 idle symbols.
// Ordered sets are only started at packet boundaries; the packet source is
// held off (pkt_ready_o low) while an ordered set is on the wire.
// Optional feature: define TX_OS_STATS_EN to add saturating SKP/TS COM counters
// (skp_count_o, ts_count_o).
module tx_ordered_set_framer #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter logic [7:0]  N_FTS        = 8'd16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_enable_i,
  input  logic [7:0] pkt_byte_i,
  input  logic       pkt_valid_i,
  input  logic       pkt_sop_i,
  input  logic       pkt_eop_i,
  output logic       pkt_ready_o,
  input  logic       ts_req_i,
  input  logic       ts_type_i,
  input  logic [7:0] link_num_i,
  input  logic [7:0] lane_num_i,
  output logic       ts_done_o,
  output logic [7:0] data_frame_o,
  output logic       data_frame_valid_o,
  output logic       is_k_o,
  output logic       is_ordered_set_o,
  output logic       bypass_scrambler_o
`ifdef TX_OS_STATS_EN
  ,
  output logic [15:0] skp_count_o,
  output logic [15:0] ts_count_o
`endif
);

  localparam logic [7:0]  SYM_COM  = 8'hBC;
  localparam logic [7:0]  SYM_SKP  = 8'h1C;
  localparam logic [7:0]  SYM_PAD  = 8'hF7;
  localparam logic [11:0] CNT_LAST = 12'(SKP_INTERVAL - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_SKP, ST_TS} state_t;

  state_t     state_q;
  logic [3:0] idx_q;
  logic [11:0] cnt_q;
  logic       skp_pending_q;
  logic       ts_type_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       k_q;
  logic       os_q;
  logic       done_q;

  logic [7:0] ts_data_d;
  logic       ts_k_d;
  logic       cnt_wrap_d;

  assign cnt_wrap_d = (cnt_q == CNT_LAST);

  // Packet bytes are taken mid-packet, or in IDLE when no ordered set is waiting.
  assign pkt_ready_o = tx_enable_i &
                       ((state_q == ST_PKT) |
                        ((state_q == ST_IDLE) & ~skp_pending_q & ~ts_req_i));

  // TS body symbol for the current index (COM is emitted from IDLE).
  always_comb begin
    ts_data_d = ts_type_q ? 8'h45 : 8'h4A;
    ts_k_d    = 1'b0;
    case (idx_q)
      4'd1: begin
        ts_data_d = link_num_i;
        ts_k_d    = (link_num_i == SYM_PAD);
      end
      4'd2: begin
        ts_data_d = lane_num_i;
        ts_k_d    = (lane_num_i == SYM_PAD);
      end
      4'd3:    ts_data_d = N_FTS;
      4'd4:    ts_data_d = 8'h02;
      4'd5:    ts_data_d = 8'h00;
      default: ;
    endcase
  end

  // Framer FSM, SKP scheduler and registered symbol outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i || !tx_enable_i) begin
      state_q       <= ST_IDLE;
      idx_q         <= 4'd0;
      cnt_q         <= 12'd0;
      skp_pending_q <= 1'b0;
      ts_type_q     <= 1'b0;
      data_q        <= 8'h00;
      valid_q       <= 1'b0;
      k_q           <= 1'b0;
      os_q          <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      k_q     <= 1'b0;
      os_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= cnt_wrap_d ? 12'd0 : cnt_q + 12'd1;

      case (state_q)
        ST_IDLE: begin
          if (skp_pending_q) begin
            data_q        <= SYM_COM;
            valid_q       <= 1'b1;
            k_q           <= 1'b1;
            os_q          <= 1'b1;
            skp_pending_q <= 1'b0;
            idx_q         <= 4'd1;
            state_q       <= ST_SKP;
          end else if (ts_req_i) begin
            data_q    <= SYM_COM;
            valid_q   <= 1'b1;
            k_q       <= 1'b1;
            os_q      <= 1'b1;
            ts_type_q <= ts_type_i;
            idx_q     <= 4'd1;
            state_q   <= ST_TS;
          end else if (pkt_valid_i && pkt_sop_i) begin
            data_q  <= pkt_byte_i;
            valid_q <= 1'b1;
            if (!pkt_eop_i) state_q <= ST_PKT;
          end else begin
            valid_q <= 1'b1;
          end
        end
        ST_PKT: begin
          if (pkt_valid_i) begin
            data_q  <= pkt_byte_i;
            valid_q <= 1'b1;
            if (pkt_eop_i) state_q <= ST_IDLE;
          end
        end
        ST_SKP: begin
          data_q  <= SYM_SKP;
          valid_q <= 1'b1;
          k_q     <= 1'b1;
          os_q    <= 1'b1;
          if (idx_q == 4'd3) begin
            idx_q   <= 4'd0;
            state_q <= ST_IDLE;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        ST_TS: begin
          data_q  <= ts_data_d;
          valid_q <= 1'b1;
          k_q     <= ts_k_d;
          os_q    <= 1'b1;
          if (idx_q == 4'd15) begin
            // Back-to-back repeat is decided by IDLE on the very next cycle,
            // so a SKP that became due during this TS still wins, with no gap.
            done_q  <= 1'b1;
            idx_q   <= 4'd0;
            state_q <= ST_IDLE;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        default: begin
          idx_q   <= 4'd0;
          state_q <= ST_IDLE;
        end
      endcase

      // A SKP falling due while the previous one is being launched keeps pending set.
      if (cnt_wrap_d) skp_pending_q <= 1'b1;
    end
  end

  assign data_frame_o       = data_q;
  assign data_frame_valid_o = valid_q;
  assign is_k_o             = k_q;
  assign is_ordered_set_o   = os_q;
  assign bypass_scrambler_o = os_q;
  assign ts_done_o          = done_q;

`ifdef TX_OS_STATS_EN
  logic        skp_com;
  logic        ts_com;
  logic [15:0] skp_count_q;
  logic [15:0] ts_count_q;

  assign skp_com = tx_enable_i && (state_q == ST_IDLE) && skp_pending_q;
  assign ts_com  = tx_enable_i && (state_q == ST_IDLE) && !skp_pending_q && ts_req_i;

  // Saturating counts of SKP and TS COM symbols emitted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skp_count_q <= 16'd0;
      ts_count_q  <= 16'd0;
    end else begin
      if (skp_com && skp_count_q != 16'hFFFF) skp_count_q <= skp_count_q + 16'd1;
      if (ts_com && ts_count_q != 16'hFFFF) ts_count_q <= ts_count_q + 16'd1;
    end
  end

  assign skp_count_o = skp_count_q;
  assign ts_count_o  = ts_count_q;
`endif

endmodule

// File: tb/tb_tx_ordered_set_framer.sv
// Testbench for tx_ordered_set_framer: a short vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_tx_ordered_set_framer;

  localparam int         INTERVAL = 16;
  localparam logic [7:0] NFTS     = 8'd16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] pbyte = 8'h00;
  logic       pvalid = 1'b0, psop = 1'b0, peop = 1'b0;
  logic       ready;
  logic       ts_req = 1'b0, ts_type = 1'b0;
  logic [7:0] link = 8'hF7, lane = 8'hF7;
  logic       done;
  logic [7:0] dout;
  logic       dvalid, isk, isos, byp;
`ifdef TX_OS_STATS_EN
  logic [15:0] skp_cnt, ts_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tx_ordered_set_framer #(.SKP_INTERVAL(INTERVAL), .N_FTS(NFTS)) dut (
    .clk_i(clk), .rst_i(rst), .tx_enable_i(en),
    .pkt_byte_i(pbyte), .pkt_valid_i(pvalid), .pkt_sop_i(psop), .pkt_eop_i(peop),
    .pkt_ready_o(ready),
    .ts_req_i(ts_req), .ts_type_i(ts_type), .link_num_i(link), .lane_num_i(lane),
    .ts_done_o(done), .data_frame_o(dout), .data_frame_valid_o(dvalid),
    .is_k_o(isk), .is_ordered_set_o(isos), .bypass_scrambler_o(byp)
`ifdef TX_OS_STATS_EN
    , .skp_count_o(skp_cnt), .ts_count_o(ts_cnt)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit e, v, s, o, input logic [7:0] b, input bit tr, tt);
    en = e; pvalid = v; psop = s; peop = o; pbyte = b; ts_req = tr; ts_type = tt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Expected TS symbol i as {done, k, data}.
  function automatic logic [9:0] ts_exp(input int i, input bit tt, input logic [7:0] ln, input logic [7:0] la);
    case (i)
      0:       return {1'b0, 1'b1, 8'hBC};
      1:       return {1'b0, ln == 8'hF7, ln};
      2:       return {1'b0, la == 8'hF7, la};
      3:       return {2'b00, NFTS};
      4:       return {2'b00, 8'h02};
      5:       return {2'b00, 8'h00};
      default: return {i == 15, 1'b0, tt ? 8'h45 : 8'h4A};
    endcase
  endfunction

  // Checks one ordered-set symbol on the output.
  task automatic chk_os(input string name, input logic [9:0] e);
    chk({name, ".valid"}, 16'(dvalid), 16'd1);
    chk({name, ".data"}, 16'(dout), 16'(e[7:0]));
    chk({name, ".k"}, 16'(isk), 16'(e[8]));
    chk({name, ".os"}, 16'(isos), 16'd1);
    chk({name, ".byp"}, 16'(byp), 16'd1);
    chk({name, ".done"}, 16'(done), 16'(e[9]));
  endtask

  function automatic logic [9:0] skp_exp(input int i);
    return (i == 0) ? {2'b01, 8'hBC} : {2'b01, 8'h1C};
  endfunction

  // ---------------- table-driven vectors ----------------
  typedef struct {
    bit en, v, s, e;
    logic [7:0] b;
    bit tr, tt;
    bit rdy;
    logic [7:0] d;
    bit dv, k, os;
  } vec_t;

  vec_t tbl[10];

  // ---------------- behavioural reference model ----------------
  typedef struct packed {logic done; logic k; logic [7:0] d;} sym_t;
  sym_t mq[$];
  bit   m_in_pkt;
  bit   m_pend;
  int   m_cyc;
  int   m_skp_n, m_ts_n;
  logic [7:0] e_d;
  bit   e_v, e_k, e_os, e_done;

  function automatic void m_clear(input bit full);
    mq.delete();
    m_in_pkt = 1'b0;
    m_pend = 1'b0;
    m_cyc = 0;
    if (full) begin
      m_skp_n = 0;
      m_ts_n = 0;
    end
  endfunction

  function automatic bit m_ready();
    return en && (mq.size() == 0) && (m_in_pkt || (!m_pend && !ts_req));
  endfunction

  // One cycle of the model, from the inputs currently applied.
  function automatic void m_step();
    sym_t s;
    e_d = 8'h00; e_v = 1'b0; e_k = 1'b0; e_os = 1'b0; e_done = 1'b0;
    if (rst || !en) begin
      m_clear(rst);
      return;
    end
    if (mq.size() == 0 && !m_in_pkt) begin
      if (m_pend) begin
        for (int i = 0; i < 4; i++) mq.push_back(sym_t'(skp_exp(i)));
        m_pend = 1'b0;
        if (m_skp_n < 65535) m_skp_n++;
      end else if (ts_req) begin
        for (int i = 0; i < 16; i++) mq.push_back(sym_t'(ts_exp(i, ts_type, link, lane)));
        if (m_ts_n < 65535) m_ts_n++;
      end else if (pvalid && psop) begin
        e_d = pbyte; e_v = 1'b1;
        m_in_pkt = !peop;
      end else begin
        e_v = 1'b1;
      end
    end else if (mq.size() == 0) begin
      if (pvalid) begin
        e_d = pbyte; e_v = 1'b1;
        if (peop) m_in_pkt = 1'b0;
      end
    end
    if (!e_v && mq.size() != 0) begin
      s = mq.pop_front();
      e_d = s.d; e_k = s.k; e_done = s.done; e_v = 1'b1; e_os = 1'b1;
    end
    m_cyc++;
    if (m_cyc == INTERVAL) begin
      m_cyc = 0;
      m_pend = 1'b1;
    end
  endfunction

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rst    = ($urandom_range(0, 399) == 0);
      en     = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 29) == 0) ts_req = ~ts_req;
      ts_type = 1'($urandom);
      pvalid = ($urandom_range(0, 9) < 7);
      psop   = ($urandom_range(0, 4) == 0);
      peop   = ($urandom_range(0, 4) == 0);
      pbyte  = 8'($urandom);
      #1;
      chk("rnd.ready", 16'(ready), 16'(m_ready()));
      m_step();
      tick();
      chk("rnd.valid", 16'(dvalid), 16'(e_v));
      if (e_v) chk("rnd.data", 16'(dout), 16'(e_d));
      chk("rnd.k", 16'(isk), 16'(e_k));
      chk("rnd.os", 16'(isos), 16'(e_os));
      chk("rnd.byp", 16'(byp), 16'(e_os));
      chk("rnd.done", 16'(done), 16'(e_done));
`ifdef TX_OS_STATS_EN
      chk("rnd.skp_count", skp_cnt, 16'(m_skp_n));
      chk("rnd.ts_count", ts_cnt, 16'(m_ts_n));
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1,0,0,0,8'h00,0,0, 1, 8'h00,1,0,0};
    tbl[1] = '{1,1,1,1,8'hA5,0,0, 1, 8'hA5,1,0,0};
    tbl[2] = '{1,1,0,0,8'h33,0,0, 1, 8'h00,1,0,0};
    tbl[3] = '{1,1,1,0,8'h10,0,0, 1, 8'h10,1,0,0};
    tbl[4] = '{1,0,0,0,8'h00,0,0, 1, 8'h00,0,0,0};
    tbl[5] = '{1,1,1,0,8'h22,0,0, 1, 8'h22,1,0,0};
    tbl[6] = '{1,1,0,1,8'h11,1,0, 1, 8'h11,1,0,0};
    tbl[7] = '{1,0,0,0,8'h00,1,1, 0, 8'hBC,1,1,1};
    tbl[8] = '{0,0,0,0,8'h00,1,0, 0, 8'h00,0,0,0};
    tbl[9] = '{1,0,0,0,8'h00,0,0, 1, 8'h00,1,0,0};

    // Reset state
    drive(1, 0, 0, 0, 8'h00, 0, 0);
    do_reset();
    chk("reset.valid", 16'(dvalid), 16'd0);
    chk("reset.data", 16'(dout), 16'd0);
    chk("reset.k", 16'(isk), 16'd0);
    chk("reset.os", 16'(isos), 16'd0);
    chk("reset.done", 16'(done), 16'd0);
    $display("reset checked");

    // Vector table
    drive(1, 0, 0, 0, 8'h00, 0, 0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].en, tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].b, tbl[i].tr, tbl[i].tt);
      #1;
      chk("tbl.ready", 16'(ready), 16'(tbl[i].rdy));
      tick();
      chk("tbl.valid", 16'(dvalid), 16'(tbl[i].dv));
      if (tbl[i].dv) chk("tbl.data", 16'(dout), 16'(tbl[i].d));
      chk("tbl.k", 16'(isk), 16'(tbl[i].k));
      chk("tbl.os", 16'(isos), 16'(tbl[i].os));
      chk("tbl.done", 16'(done), 16'd0);
      $display("vector %0d: out=%02h valid=%0b k=%0b os=%0b", i, dout, dvalid, isk, isos);
    end

    // Periodic SKP with no traffic: COM on edges 17 and 33
    drive(1, 0, 0, 0, 8'h00, 0, 0);
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n >= 17 && ((n - 17) % 16) < 4) chk_os("skp_idle", skp_exp((n - 17) % 16));
      else begin
        chk("idle.valid", 16'(dvalid), 16'd1);
        chk("idle.data", 16'(dout), 16'h00);
        chk("idle.os", 16'(isos), 16'd0);
      end
    end
    $display("periodic SKP sequence done");

    // TS1 with PAD link/lane, SKP falling due mid-TS, then TS2
    link = 8'hF7; lane = 8'hF7;
    drive(1, 0, 0, 0, 8'h00, 1, 0);
    do_reset();
    for (int n = 1; n <= 37; n++) begin
      if (n == 2) ts_type = 1'b1;
      tick();
      if (n <= 16) chk_os("ts1", ts_exp(n - 1, 0, 8'hF7, 8'hF7));
      else if (n <= 20) chk_os("skp_ts", skp_exp(n - 17));
      else if (n <= 36) chk_os("ts2", ts_exp(n - 21, 1, 8'hF7, 8'hF7));
      else chk_os("skp_ts2", skp_exp(0));
    end
`ifdef TX_OS_STATS_EN
    chk("stats.skp", skp_cnt, 16'd2);
    chk("stats.ts", ts_cnt, 16'd2);
`endif
    $display("TS/SKP priority sequence done");

    // 8-byte packet with SKP due at byte 3
    drive(1, 0, 0, 0, 8'h00, 0, 0);
    do_reset();
    for (int n = 1; n <= 24; n++) begin
      if (n >= 13 && n <= 20) drive(1, 1, n == 13, n == 20, 8'(8'h10 + n - 13), 0, 0);
      else drive(1, 0, 0, 0, 8'h00, 0, 0);
      #1;
      if (n >= 13 && n <= 20) chk("pkt.ready", 16'(ready), 16'd1);
      if (n >= 22) chk("skp.ready", 16'(ready), 16'd0);
      tick();
      if (n >= 13 && n <= 20) begin
        chk("pkt.valid", 16'(dvalid), 16'd1);
        chk("pkt.data", 16'(dout), 16'(8'h10 + n - 13));
        chk("pkt.os", 16'(isos), 16'd0);
      end else if (n >= 21) chk_os("skp_pkt", skp_exp(n - 21));
    end
    $display("packet with deferred SKP done");

    // tx_enable_i drop at TS symbol 7, then restart at COM
    link = 8'h01; lane = 8'h02;
    drive(1, 0, 0, 0, 8'h00, 1, 0);
    do_reset();
    for (int n = 1; n <= 24; n++) begin
      en = (n != 8);
      tick();
      if (n <= 7) chk_os("ts_pre", ts_exp(n - 1, 0, 8'h01, 8'h02));
      else if (n == 8) begin
        chk("abort.valid", 16'(dvalid), 16'd0);
        chk("abort.done", 16'(done), 16'd0);
        chk("abort.os", 16'(isos), 16'd0);
      end else chk_os("ts_restart", ts_exp(n - 9, 0, 8'h01, 8'h02));
    end
    $display("enable drop sequence done");

    // Randomized traffic against the model
    drive(1, 0, 0, 0, 8'h00, 0, 0);
    link = 8'hF7; lane = 8'hF7;
    do_reset();
    m_clear(1'b1);
    random_phase(3000);
    $display("random phase 1 done");
    link = 8'($urandom_range(0, 200)); lane = 8'hF7;
    drive(1, 0, 0, 0, 8'h00, 0, 0);
    do_reset();
    m_clear(1'b1);
    random_phase(3000);
    $display("random phase 2 done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
